pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Parametrised program-counter and instruction-fetch sequencer for the multicycle core.
//  Generalises PC logic: configurable PC/instruction widths, memory latency, reset vector.
//  Adds a valid/ready fetch handshake to the control unit and a call/return address stack.
//  Sits between instruction memory and Controle/ALU; drives mem address, presents instr.
// PARAMETERS
//  PC_W          12  PC / address width; all PC arithmetic modulo 2**PC_W
//  INSTR_W       16  instruction word width
//  MEM_LATENCY    1  cycles from mem_rd to valid instr_in (>=1)
//  RAS_DEPTH      4  return-address-stack entries (power of 2, >=2)
//  RESET_VECTOR   0  PC after reset and on RAS underflow
// PORTS
//  CLOCK_50      in   1        sole clock, rising edge
//  reset         in   1        asynchronous, active-low; 0 = in reset
//  mem_addr      out  PC_W     instruction memory address (= pc in S_FETCH)
//  mem_rd        out  1        read strobe, high only in S_FETCH
//  instr_in      in   INSTR_W  memory read data
//  instr_out     out  INSTR_W  registered instruction to control/datapath
//  instr_valid   out  1        instr_out holds a fetched instruction
//  instr_ready   in   1        control accepts instr_out this cycle
//  pc_en         in   1        unconditional redirect (EscCP), sampled on accept
//  pc_cond_en    in   1        conditional branch (EscCondCP), sampled on accept
//  zero          in   1        ALU zero flag, sampled on accept
//  pc_src        in   2        00 inc, 01 branch(alu_target), 10 jump(jump_imm), 11 return
//  call          in   1        with pc_en & pc_src=10: push pc+1 onto RAS
//  alu_target    in   PC_W     branch target
//  jump_imm      in   PC_W     jump target
//  pc            out  PC_W     address of instruction in instr_out
//  ras_overflow  out  1        sticky: push while RAS full
//  ras_underflow out  1        sticky: return while RAS empty
// BEHAVIOUR
//  Reset (async, reset=0): pc=RESET_VECTOR, state=S_FETCH, mem_rd=0, instr_valid=0,
//   instr_out=0, RAS empty, both sticky flags 0, latency counter 0. Mid-op reset aborts
//   any fetch; no instruction from before reset is ever presented.
//  FSM: S_FETCH: mem_rd=1, mem_addr=pc, 1 cycle -> S_WAIT.
//   S_WAIT: count MEM_LATENCY cycles; on last, capture instr_in->instr_out -> S_ISSUE.
//   S_ISSUE: instr_valid=1; instr_out, pc held stable until instr_ready=1 (accept).
//   Accept: pc<=next_pc, instr_valid deasserts next cycle, -> S_FETCH.
//  instr_valid first rises MEM_LATENCY+1 cycles after S_FETCH entry; with instr_ready
//   tied high one instruction is retired every MEM_LATENCY+2 cycles.
//  next_pc priority (evaluated on accept only):
//   pc_en & src=10 -> jump_imm (push pc+1 if call); pc_en & src=11 -> RAS pop;
//   pc_en & src=01 -> alu_target; pc_cond_en & zero -> alu_target; else pc+1.
//   pc_en=0, pc_cond_en=0 -> pc+1. Inputs ignored outside accept cycle.
//  pc+1 wraps: pc=2**PC_W-1 -> 0 without flag.
//  RAS: circular; push when full overwrites oldest, sets ras_overflow, count stays DEPTH.
//   Pop when empty -> next_pc=RESET_VECTOR, sets ras_underflow. Push/pop never same cycle.
//  Sticky flags clear only on reset.
// STRUCTURE
//  Header pc_defs.vh (`include): pc_src codes PCSRC_INC/BR/JMP/RET, FSM state codes.
//  Sub-module pc_ras: RAS_DEPTH x PC_W stack, push/pop/data/full/empty/ovf/unf,
//   same CLOCK_50/reset. Top holds FSM, latency counter, pc, instr register, next_pc mux.
// TESTING
//  Reset release, ready=1, no redirects, LAT=1 -> mem_addr 0,1,2 every 3 cycles; valid at cyc 2.
//  Hold instr_ready=0 for 5 cycles in S_ISSUE -> instr_out, pc stable; no mem_rd; then advance.
//  pc=5, pc_cond_en=1, zero=1, alu_target=0x040 -> next fetch 0x040; zero=0 -> 0x006.
//  pc=0x010 call jump_imm=0x100; at 0x100 return -> fetch 0x011; 5 calls DEPTH=4 -> ovf=1.
//  Return with empty RAS -> fetch RESET_VECTOR, ras_underflow=1 until reset.
//  pc=0xFFF increment -> 0x000; assert reset in S_WAIT -> outputs at reset values async.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// pc_fetch_unit_pkg
//   Shared types for the program-counter / instruction-fetch sequencer.
//   pcSrc_t      : next-PC source select codes driven by the control unit
//   fetchState_t : fetch sequencer states
// ----------------------------------------------------------------------------
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        PCSRC_INC = 2'b00,
        PCSRC_BR  = 2'b01,
        PCSRC_JMP = 2'b10,
        PCSRC_RET = 2'b11
    } pcSrc_t;

    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_WAIT  = 2'b01,
        S_ISSUE = 2'b10
    } fetchState_t;

endpackage

// File: rtl/pc_ras.sv
// ----------------------------------------------------------------------------
// pc_ras
//   Circular return-address stack, RAS_DEPTH entries of PC_W bits.
//   A push while full overwrites the oldest entry and sets the sticky
//   overflow flag; a pop while empty leaves the stack untouched and sets the
//   sticky underflow flag. Push and pop are never requested together; push
//   wins if they are.
// Ports
//   CLOCK_50  in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   push      in   write pushData on top
//   pop       in   discard top entry
//   pushData  in   PC_W return address to store
//   popData   out  PC_W current top entry (valid when !empty)
//   empty     out  no entries held
//   overflow  out  sticky: push while full
//   underflow out  sticky: pop while empty
// ----------------------------------------------------------------------------
module pc_ras #(
    parameter int PC_W      = 12,
    parameter int RAS_DEPTH = 4
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] pushData,
    output logic [PC_W-1:0] popData,
    output logic            empty,
    output logic            overflow,
    output logic            underflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]  stack [RAS_DEPTH];
    logic [PTR_W-1:0] topPtr;   // next free slot; wraps modulo RAS_DEPTH
    logic [CNT_W-1:0] count;
    logic             full;

    always_comb begin
        full    = (count == CNT_W'(RAS_DEPTH));
        empty   = (count == '0);
        popData = stack[topPtr - PTR_W'(1)];
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            topPtr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (push) begin
            topPtr <= topPtr + PTR_W'(1);
            if (full) begin
                overflow <= 1'b1;
            end else begin
                count <= count + CNT_W'(1);
            end
        end else if (pop) begin
            if (empty) begin
                underflow <= 1'b1;
            end else begin
                topPtr <= topPtr - PTR_W'(1);
                count  <= count - CNT_W'(1);
            end
        end
    end

    // Storage carries no reset: an entry is only ever read after being written.
    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            stack[topPtr] <= pushData;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// ----------------------------------------------------------------------------
// pc_fetch_unit
//   Program counter and instruction-fetch sequencer for the multicycle core.
//   FETCH strobes the memory at pc, WAIT counts MEM_LATENCY cycles and
//   captures the read data, ISSUE presents it with instr_valid until the
//   control unit accepts it; on accept the PC advances to next_pc.
// Ports
//   CLOCK_50      in   clock, rising edge
//   reset         in   asynchronous active-low reset
//   mem_addr      out  instruction memory address (pc)
//   mem_rd        out  read strobe, high in FETCH only
//   instr_in      in   memory read data
//   instr_out     out  registered instruction
//   instr_valid   out  instr_out holds a fetched instruction
//   instr_ready   in   control accepts instr_out
//   pc_en         in   unconditional redirect
//   pc_cond_en    in   conditional branch enable
//   zero          in   ALU zero flag
//   pc_src        in   00 inc, 01 branch, 10 jump, 11 return
//   call          in   with jump: push pc+1 onto the return stack
//   alu_target    in   branch target
//   jump_imm      in   jump target
//   pc            out  address of instruction in instr_out
//   ras_overflow  out  sticky: push while return stack full
//   ras_underflow out  sticky: return while return stack empty
// ----------------------------------------------------------------------------
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int PC_W         = 12,
    parameter int INSTR_W      = 16,
    parameter int MEM_LATENCY  = 1,
    parameter int RAS_DEPTH    = 4,
    parameter int RESET_VECTOR = 0
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    output logic [PC_W-1:0]    mem_addr,
    output logic               mem_rd,
    input  logic [INSTR_W-1:0] instr_in,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               pc_en,
    input  logic               pc_cond_en,
    input  logic               zero,
    input  logic [1:0]         pc_src,
    input  logic               call,
    input  logic [PC_W-1:0]    alu_target,
    input  logic [PC_W-1:0]    jump_imm,
    output logic [PC_W-1:0]    pc,
    output logic               ras_overflow,
    output logic               ras_underflow
);

    localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [PC_W-1:0] RV = PC_W'(RESET_VECTOR);

    fetchState_t      state, stateNext;
    logic [LAT_W-1:0] latCnt;
    logic             latDone;
    logic             accept;
    pcSrc_t           src;
    logic [PC_W-1:0]  pcInc;
    logic [PC_W-1:0]  nextPc;
    logic             pushReq, popReq;
    logic [PC_W-1:0]  rasTop;
    logic             rasEmpty;

    always_comb begin
        src     = pcSrc_t'(pc_src);
        accept  = (state == S_ISSUE) && instr_ready;
        latDone = (latCnt == LAT_W'(MEM_LATENCY - 1));
        pcInc   = pc + PC_W'(1);
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            state <= stateNext;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        stateNext = state;
        case (state)
            S_FETCH: stateNext = S_WAIT;
            S_WAIT:  if (latDone) stateNext = S_ISSUE;
            S_ISSUE: if (instr_ready) stateNext = S_FETCH;
            default: stateNext = S_FETCH;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // The reset state is FETCH, so the strobe is qualified by reset to keep
    // it low while reset is held.
    always_comb begin
        mem_rd      = (state == S_FETCH) && reset;
        mem_addr    = pc;
        instr_valid = (state == S_ISSUE);
    end

    // ---------------- next-PC selection (used on accept only) ----------------
    always_comb begin
        nextPc  = pcInc;
        pushReq = 1'b0;
        popReq  = 1'b0;
        if (pc_en && src == PCSRC_JMP) begin
            nextPc  = jump_imm;
            pushReq = call;
        end else if (pc_en && src == PCSRC_RET) begin
            popReq = 1'b1;
            nextPc = rasEmpty ? RV : rasTop;
        end else if (pc_en && src == PCSRC_BR) begin
            nextPc = alu_target;
        end else if (pc_cond_en && zero) begin
            nextPc = alu_target;
        end
    end

    // ---------------- PC, latency counter, instruction register ----------------
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            pc        <= RV;
            instr_out <= '0;
            latCnt    <= '0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (latDone) begin
                        instr_out <= instr_in;
                        latCnt    <= '0;
                    end else begin
                        latCnt <= latCnt + LAT_W'(1);
                    end
                end
                S_ISSUE: begin
                    if (accept) pc <= nextPc;
                end
                default: ;
            endcase
        end
    end

    pc_ras #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) uRas (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .push      (accept && pushReq),
        .pop       (accept && popReq),
        .pushData  (pcInc),
        .popData   (rasTop),
        .empty     (rasEmpty),
        .overflow  (ras_overflow),
        .underflow (ras_underflow)
    );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_pc_fetch_unit
//   Directed bench for pc_fetch_unit with default parameters
//   (PC_W=12, INSTR_W=16, MEM_LATENCY=1, RAS_DEPTH=4, RESET_VECTOR=0).
//   The memory model returns {4'hA, address} one cycle after the strobe.
// ----------------------------------------------------------------------------
module tb_pc_fetch_unit;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [11:0] mem_addr;
    logic        mem_rd;
    logic [15:0] instr_in;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        pc_en;
    logic        pc_cond_en;
    logic        zero;
    logic [1:0]  pc_src;
    logic        call;
    logic [11:0] alu_target;
    logic [11:0] jump_imm;
    logic [11:0] pc;
    logic        ras_overflow;
    logic        ras_underflow;

    int assertCount = 0;
    int failCount   = 0;

    logic [11:0] memAddrQ = '0;

    pc_fetch_unit #(
        .PC_W         (12),
        .INSTR_W      (16),
        .MEM_LATENCY  (1),
        .RAS_DEPTH    (4),
        .RESET_VECTOR (0)
    ) dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .mem_addr      (mem_addr),
        .mem_rd        (mem_rd),
        .instr_in      (instr_in),
        .instr_out     (instr_out),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .pc_en         (pc_en),
        .pc_cond_en    (pc_cond_en),
        .zero          (zero),
        .pc_src        (pc_src),
        .call          (call),
        .alu_target    (alu_target),
        .jump_imm      (jump_imm),
        .pc            (pc),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) begin
        if (mem_rd) memAddrQ <= mem_addr;
    end
    assign instr_in = {4'hA, memAddrQ};

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clearCtrl();
        instr_ready = 1'b0;
        pc_en       = 1'b0;
        pc_cond_en  = 1'b0;
        zero        = 1'b0;
        pc_src      = 2'b00;
        call        = 1'b0;
        alu_target  = '0;
        jump_imm    = '0;
    endtask

    task automatic waitValid();
        int n = 0;
        while (!instr_valid && n < 20) begin
            @(posedge CLOCK_50); #1;
            n++;
        end
        checkVal("issueTimeout", {31'b0, instr_valid}, 32'd1);
    endtask

    // Wait for ISSUE, accept with the given controls, then sample the FETCH cycle.
    task automatic acceptStep(input string tag, input logic en, input logic condEn,
                              input logic z, input logic [1:0] src, input logic cl,
                              input logic [11:0] aluT, input logic [11:0] jImm,
                              input logic [11:0] expAddr);
        waitValid();
        pc_en       = en;
        pc_cond_en  = condEn;
        zero        = z;
        pc_src      = src;
        call        = cl;
        alu_target  = aluT;
        jump_imm    = jImm;
        instr_ready = 1'b1;
        @(posedge CLOCK_50); #1;
        clearCtrl();
        checkVal({tag, "Rd"}, {31'b0, mem_rd}, 32'd1);
        checkVal(tag, {20'b0, mem_addr}, {20'b0, expAddr});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        clearCtrl();
        #12;
        checkVal("rstPc",     {20'b0, pc}, 32'h0);
        checkVal("rstMemRd",  {31'b0, mem_rd}, 32'd0);
        checkVal("rstValid",  {31'b0, instr_valid}, 32'd0);
        checkVal("rstInstr",  {16'b0, instr_out}, 32'h0);
        checkVal("rstOvf",    {31'b0, ras_overflow}, 32'd0);
        checkVal("rstUnf",    {31'b0, ras_underflow}, 32'd0);

        // Free-running fetch, ready tied high: one instruction per 3 cycles
        @(negedge CLOCK_50);
        reset       = 1'b1;
        instr_ready = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            checkVal("seqFetchRd",   {31'b0, mem_rd}, 32'd1);
            checkVal("seqFetchAddr", {20'b0, mem_addr}, k);
            @(posedge CLOCK_50); #1;
            checkVal("seqWaitRd",    {31'b0, mem_rd}, 32'd0);
            checkVal("seqWaitValid", {31'b0, instr_valid}, 32'd0);
            @(posedge CLOCK_50); #1;
            checkVal("seqIssueValid", {31'b0, instr_valid}, 32'd1);
            checkVal("seqIssuePc",    {20'b0, pc}, k);
            checkVal("seqIssueInstr", {16'b0, instr_out}, 32'hA000 + k);
            @(posedge CLOCK_50); #1;
        end

        // Stall in ISSUE with ready low
        checkVal("stallFetchAddr", {20'b0, mem_addr}, 32'h3);
        instr_ready = 1'b0;
        @(posedge CLOCK_50); #1;
        @(posedge CLOCK_50); #1;
        checkVal("stallValid", {31'b0, instr_valid}, 32'd1);
        repeat (5) begin
            @(posedge CLOCK_50); #1;
            checkVal("stallHoldValid", {31'b0, instr_valid}, 32'd1);
            checkVal("stallHoldRd",    {31'b0, mem_rd}, 32'd0);
            checkVal("stallHoldPc",    {20'b0, pc}, 32'h3);
            checkVal("stallHoldInstr", {16'b0, instr_out}, 32'hA003);
        end
        instr_ready = 1'b1;
        @(posedge CLOCK_50); #1;
        checkVal("stallAdvRd",   {31'b0, mem_rd}, 32'd1);
        checkVal("stallAdvAddr", {20'b0, mem_addr}, 32'h4);
        clearCtrl();

        // Conditional branch taken / not taken from pc=5
        acceptStep("incTo5",   0, 0, 0, 2'b00, 0, 12'h000, 12'h000, 12'h005);
        acceptStep("condTake", 0, 1, 1, 2'b00, 0, 12'h040, 12'h000, 12'h040);
        acceptStep("jmpTo5",   1, 0, 0, 2'b10, 0, 12'h000, 12'h005, 12'h005);
        acceptStep("condSkip", 0, 1, 0, 2'b00, 0, 12'h040, 12'h000, 12'h006);
        acceptStep("brUncond", 1, 0, 0, 2'b01, 0, 12'h010, 12'h000, 12'h010);

        // Call / return
        acceptStep("call100",  1, 0, 0, 2'b10, 1, 12'h000, 12'h100, 12'h100);
        acceptStep("ret011",   1, 0, 0, 2'b11, 0, 12'h000, 12'h000, 12'h011);
        checkVal("ovfClear", {31'b0, ras_overflow}, 32'd0);

        // Five nested calls into a 4-deep stack
        acceptStep("call200",  1, 0, 0, 2'b10, 1, 12'h000, 12'h200, 12'h200);
        acceptStep("call300",  1, 0, 0, 2'b10, 1, 12'h000, 12'h300, 12'h300);
        acceptStep("call400",  1, 0, 0, 2'b10, 1, 12'h000, 12'h400, 12'h400);
        acceptStep("call500",  1, 0, 0, 2'b10, 1, 12'h000, 12'h500, 12'h500);
        checkVal("ovfAtFull", {31'b0, ras_overflow}, 32'd0);
        acceptStep("call600",  1, 0, 0, 2'b10, 1, 12'h000, 12'h600, 12'h600);
        checkVal("ovfSet",    {31'b0, ras_overflow}, 32'd1);

        // Oldest (0x012) was overwritten; four returns, then underflow
        acceptStep("ret501",   1, 0, 0, 2'b11, 0, 12'h000, 12'h000, 12'h501);
        acceptStep("ret401",   1, 0, 0, 2'b11, 0, 12'h000, 12'h000, 12'h401);
        acceptStep("ret301",   1, 0, 0, 2'b11, 0, 12'h000, 12'h000, 12'h301);
        acceptStep("ret201",   1, 0, 0, 2'b11, 0, 12'h000, 12'h000, 12'h201);
        checkVal("unfClear",  {31'b0, ras_underflow}, 32'd0);
        acceptStep("retEmpty", 1, 0, 0, 2'b11, 0, 12'h000, 12'h000, 12'h000);
        checkVal("unfSet",    {31'b0, ras_underflow}, 32'd1);
        acceptStep("incAfterUnf", 0, 0, 0, 2'b00, 0, 12'h000, 12'h000, 12'h001);
        checkVal("unfSticky", {31'b0, ras_underflow}, 32'd1);
        checkVal("ovfSticky", {31'b0, ras_overflow}, 32'd1);

        // PC wrap
        acceptStep("jmpFFF",   1, 0, 0, 2'b10, 0, 12'h000, 12'hFFF, 12'hFFF);
        acceptStep("wrap000",  0, 0, 0, 2'b00, 0, 12'h000, 12'h000, 12'h000);

        // Asynchronous reset while in WAIT
        acceptStep("jmp123",   1, 0, 0, 2'b10, 0, 12'h000, 12'h123, 12'h123);
        @(posedge CLOCK_50); #1;
        checkVal("preRstWait", {31'b0, mem_rd}, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        checkVal("asyncRstPc",    {20'b0, pc}, 32'h0);
        checkVal("asyncRstRd",    {31'b0, mem_rd}, 32'd0);
        checkVal("asyncRstValid", {31'b0, instr_valid}, 32'd0);
        checkVal("asyncRstInstr", {16'b0, instr_out}, 32'h0);
        checkVal("asyncRstOvf",   {31'b0, ras_overflow}, 32'd0);
        checkVal("asyncRstUnf",   {31'b0, ras_underflow}, 32'd0);

        @(negedge CLOCK_50);
        reset = 1'b1;
        #1;
        checkVal("postRstAddr", {20'b0, mem_addr}, 32'h0);
        waitValid();
        checkVal("postRstPc",    {20'b0, pc}, 32'h0);
        checkVal("postRstInstr", {16'b0, instr_out}, 32'hA000);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
